id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with operand bypassing and load-use hazard detection for the 5-stage MIPS core. Captures decoded fields and register-file read data (RD1/RD2) at the end of ID and presents forwarded operands to EX. Sits directly downstream of the register file and upstream of the ALU. Covers the RF's late write-back: a value written in the same cycle it is read is captured via bypass, not from RD1/RD2.

## Interface
- CTRL_W, 16, width of opaque EX/MEM/WB control bundle passed through
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  PC of ID instruction
- id_rs, id_rt  in  5  source register numbers (RF A1/A2)
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
- id_rd1, id_rd2  in  32  RF RD1/RD2
- id_dst  in  5  destination register (RF A3 later)
- id_regwrite, id_memread  in  1  writes a register / is a load
- id_imm  in  32  extended immediate
- id_ctrl  in  CTRL_W  control bundle
- mem_regwrite  in  1; mem_dst  in  5; mem_result  in  32  EX/MEM producer
- wb_regwrite  in  1; wb_dst  in  5; wb_wdata  in  32  MEM/WB producer (same as RF RFWr/A3/WD)
- hold  in  1  EX stalled by downstream; freeze this stage
- flush  in  1  kill instruction entering EX
- ex_valid  out  1; ex_pc  out  32; ex_rs, ex_rt, ex_dst  out  5; ex_regwrite, ex_memread  out  1; ex_imm  out  32; ex_ctrl  out  CTRL_W  registered copies
- ex_opa, ex_opb  out  32  forwarded rs / rt operand values (combinational)
- stall  out  1  load-use hazard: freeze PC and IF/ID, bubble inserted here

## Operation
- Registered state: all ex_* fields plus internal ex_rs_val, ex_rt_val.
- Update priority each rising edge: rst > hold > flush > stall > load.
  - rst: every register 0 (ex_valid=0, ex_opa/ex_opb then evaluate to 0).
  - hold: all fields keep value, except WB refresh (below). flush/stall ignored; sources keep them asserted until hold drops.
  - flush or stall: ex_valid<=0, ex_regwrite<=0, ex_memread<=0; other fields don't-care.
  - load: all fields <= id_*; ex_valid<=id_valid; regwrite/memread gated by id_valid.
- Capture bypass (load only): ex_rs_val <= (wb_regwrite && wb_dst!=0 && wb_dst==id_rs) ? wb_wdata : id_rd1; same for rt/id_rd2.
- WB refresh: every non-reset edge, including during hold, if ex_valid && wb_regwrite && wb_dst!=0 && wb_dst==ex_rs then ex_rs_val<=wb_wdata (same for rt). Not applied on load edges; capture bypass covers those.
- EX forwarding (combinational): ex_opa = mem match ? mem_result : wb match ? wb_wdata : ex_rs_val. Match = *_regwrite && *_dst!=0 && *_dst==ex_rs. MEM beats WB. Same for ex_opb with ex_rt. Register 0 never forwarded.
- stall = id_valid && ex_valid && ex_memread && ex_dst!=0 && ((id_use_rs && id_rs==ex_dst) || (id_use_rt && id_rt==ex_dst)). Combinational. Asserted regardless of hold.

## Timing
- Latency 1 cycle ID->EX. Throughput 1/cycle absent stall/hold.
- Load-use costs exactly 1 bubble. Next cycle the load is in MEM, so the stall condition clears and the result is forwarded from WB when the dependent sits in EX.
- hold held N cycles: outputs stable N cycles except refreshed operands. Resumes on the first edge with hold=0.
- Back-to-back writes to the same register: youngest producer (MEM) wins.

## Test plan
- Reset: rst=1 two cycles with id_valid=1 -> ex_valid=0, ex_opa=ex_opb=0, stall=0.
- Forwarding priority: ex_rs=5, mem_dst=5/mem_result=0x11111111, wb_dst=5/wb_wdata=0x22222222 -> ex_opa=0x11111111. mem_regwrite=0 -> 0x22222222. ex_rs=0 with both matching -> ex_opa=ex_rs_val.
- Capture bypass: id_rs=8, id_rd1=0xDEAD0000, wb_dst=8, wb_wdata=0x00000042, load edge -> next cycle ex_opa=0x00000042 with no mem/wb match.
- Load-use: lw $3 in EX (ex_memread=1, ex_dst=3), ID add reads $3 with id_use_rs=1 -> stall=1, next ex_valid=0. Following cycle stall=0, add loads. With id_use_rs=0 or id_rs=0 -> stall=0.
- Hold with refresh: hold=1 for 3 cycles, ex_rt=9, wb writes $9=0xCAFEF00D in cycle 2 -> ex_pc/ex_ctrl unchanged; ex_opb=0xCAFEF00D in cycle 3 after wb_regwrite drops.
- Priority: hold=1 and flush=1 together -> ex_valid unchanged. hold=0, flush=1 -> ex_valid=0. rst=1 with hold=1 -> all zero.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, EX/MEM and MEM/WB producers, and EX-side outputs of the ID/EX register
interface id_ex_stage_if #(parameter int CTRL_W = 16);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [31:0]       id_rd1;
  logic [31:0]       id_rd2;
  logic [4:0]        id_dst;
  logic              id_regwrite;
  logic              id_memread;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              mem_regwrite;
  logic [4:0]        mem_dst;
  logic [31:0]       mem_result;
  logic              wb_regwrite;
  logic [4:0]        wb_dst;
  logic [31:0]       wb_wdata;
  logic              hold;
  logic              flush;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_dst;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [31:0]       ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_opa;
  logic [31:0]       ex_opb;
  logic              stall;
  modport master (
    output id_valid, id_pc, id_rs, id_rt, id_use_rs, id_use_rt, id_rd1, id_rd2,
           id_dst, id_regwrite, id_memread, id_imm, id_ctrl,
           mem_regwrite, mem_dst, mem_result, wb_regwrite, wb_dst, wb_wdata, hold, flush,
    input  ex_valid, ex_pc, ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_imm, ex_ctrl,
           ex_opa, ex_opb, stall
  );
  modport slave (
    input  id_valid, id_pc, id_rs, id_rt, id_use_rs, id_use_rt, id_rd1, id_rd2,
           id_dst, id_regwrite, id_memread, id_imm, id_ctrl,
           mem_regwrite, mem_dst, mem_result, wb_regwrite, wb_dst, wb_wdata, hold, flush,
    output ex_valid, ex_pc, ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_imm, ex_ctrl,
           ex_opa, ex_opb, stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with capture bypass, WB refresh, EX forwarding and load-use stall
module id_ex_stage #(
  parameter int CTRL_W = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  logic              valid;
  logic [31:0]       pc;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        dst;
  logic              regwrite;
  logic              memread;
  logic [31:0]       imm;
  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       rs_val;
  logic [31:0]       rt_val;
  logic              stall;
  logic              load;

  // register 0 is hardwired, so a producer targeting it never supplies a value
  function automatic logic hit(input logic rw, input logic [4:0] d, input logic [4:0] r);
    return rw && d != 5'd0 && d == r;
  endfunction

  // load-use hazard: the loaded value is not available for an instruction entering EX next cycle
  always_comb begin
    stall = bus.id_valid && valid && memread && dst != 5'd0 &&
            ((bus.id_use_rs && bus.id_rs == dst) || (bus.id_use_rt && bus.id_rt == dst));
    load  = !bus.hold && !bus.flush && !stall;
  end

  // pipeline register: reset, load with capture bypass, or keep with bubble/WB refresh
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= '0;
      rs       <= '0;
      rt       <= '0;
      dst      <= '0;
      regwrite <= 1'b0;
      memread  <= 1'b0;
      imm      <= '0;
      ctrl     <= '0;
      rs_val   <= '0;
      rt_val   <= '0;
    end else if (load) begin
      valid    <= bus.id_valid;
      pc       <= bus.id_pc;
      rs       <= bus.id_rs;
      rt       <= bus.id_rt;
      dst      <= bus.id_dst;
      regwrite <= bus.id_regwrite && bus.id_valid;
      memread  <= bus.id_memread && bus.id_valid;
      imm      <= bus.id_imm;
      ctrl     <= bus.id_ctrl;
      rs_val   <= hit(bus.wb_regwrite, bus.wb_dst, bus.id_rs) ? bus.wb_wdata : bus.id_rd1;
      rt_val   <= hit(bus.wb_regwrite, bus.wb_dst, bus.id_rt) ? bus.wb_wdata : bus.id_rd2;
    end else begin
      if (!bus.hold) begin
        valid    <= 1'b0;
        regwrite <= 1'b0;
        memread  <= 1'b0;
      end
      if (valid && hit(bus.wb_regwrite, bus.wb_dst, rs)) rs_val <= bus.wb_wdata;
      if (valid && hit(bus.wb_regwrite, bus.wb_dst, rt)) rt_val <= bus.wb_wdata;
    end
  end

  // EX operand forwarding: youngest producer (MEM) beats WB, which beats the stored value
  always_comb begin
    bus.ex_opa = hit(bus.mem_regwrite, bus.mem_dst, rs) ? bus.mem_result :
                 hit(bus.wb_regwrite, bus.wb_dst, rs)   ? bus.wb_wdata   : rs_val;
    bus.ex_opb = hit(bus.mem_regwrite, bus.mem_dst, rt) ? bus.mem_result :
                 hit(bus.wb_regwrite, bus.wb_dst, rt)   ? bus.wb_wdata   : rt_val;
  end

  assign bus.ex_valid    = valid;
  assign bus.ex_pc       = pc;
  assign bus.ex_rs       = rs;
  assign bus.ex_rt       = rt;
  assign bus.ex_dst      = dst;
  assign bus.ex_regwrite = regwrite;
  assign bus.ex_memread  = memread;
  assign bus.ex_imm      = imm;
  assign bus.ex_ctrl     = ctrl;
  assign bus.stall       = stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven load/check vectors plus hand sequences for reset, load-use, hold and priority
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if #(.CTRL_W(16)) bus ();
  id_ex_stage #(.CTRL_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  dst;
    logic        mr;
    logic        lwrw;
    logic [4:0]  lwdst;
    logic [31:0] lwwd;
    logic        mrw;
    logic [4:0]  mdst;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wdst;
    logic [31:0] wwd;
    logic [4:0]  nrs;
    logic [4:0]  nrt;
    logic        nurs;
    logic        nurt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        st;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic iv, input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [4:0] dst, input logic rw, input logic mr);
    bus.id_valid    = iv;
    bus.id_pc       = pc;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_rd1      = rd1;
    bus.id_rd2      = rd2;
    bus.id_dst      = dst;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_imm      = ~pc;
    bus.id_ctrl     = pc[15:0] ^ 16'hA5A5;
  endtask

  task automatic drive_fw(input logic mrw, input logic [4:0] mdst, input logic [31:0] mres,
                          input logic wrw, input logic [4:0] wdst, input logic [31:0] wwd);
    bus.mem_regwrite = mrw;
    bus.mem_dst      = mdst;
    bus.mem_result   = mres;
    bus.wb_regwrite  = wrw;
    bus.wb_dst       = wdst;
    bus.wb_wdata     = wwd;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{5'd5, 5'd6, 32'h0000000A, 32'h0000000B, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 5'd0, 5'd0, 1'b0, 1'b0,
                32'h11111111, 32'h0000000B, 1'b0};
    tbl[1]  = '{5'd5, 5'd6, 32'h0000000A, 32'h0000000B, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 5'd0, 5'd0, 1'b0, 1'b0,
                32'h22222222, 32'h0000000B, 1'b0};
    tbl[2]  = '{5'd0, 5'd6, 32'h12340000, 32'h0000000B, 5'd7, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF,
                1'b1, 5'd0, 32'h11111111, 1'b1, 5'd0, 32'h22222222, 5'd0, 5'd0, 1'b0, 1'b0,
                32'h12340000, 32'h0000000B, 1'b0};
    tbl[3]  = '{5'd8, 5'd9, 32'hDEAD0000, 32'h00000099, 5'd7, 1'b0, 1'b1, 5'd8, 32'h00000042,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0,
                32'h00000042, 32'h00000099, 1'b0};
    tbl[4]  = '{5'd1, 5'd10, 32'h00000001, 32'h00000002, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd11, 32'h00000033, 1'b1, 5'd10, 32'h00000077, 5'd0, 5'd0, 1'b0, 1'b0,
                32'h00000001, 32'h00000077, 1'b0};
    tbl[5]  = '{5'd2, 5'd10, 32'h00000005, 32'h00000006, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd10, 32'h0000AAAA, 1'b1, 5'd10, 32'h0000BBBB, 5'd0, 5'd0, 1'b0, 1'b0,
                32'h00000005, 32'h0000AAAA, 1'b0};
    tbl[6]  = '{5'd1, 5'd2, 32'h00000010, 32'h00000020, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0,
                32'h00000010, 32'h00000020, 1'b1};
    tbl[7]  = '{5'd1, 5'd2, 32'h00000010, 32'h00000020, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 1'b0,
                32'h00000010, 32'h00000020, 1'b0};
    tbl[8]  = '{5'd1, 5'd2, 32'h00000010, 32'h00000020, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1,
                32'h00000010, 32'h00000020, 1'b0};
    tbl[9]  = '{5'd1, 5'd2, 32'h00000010, 32'h00000020, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd4, 1'b1, 1'b1,
                32'h00000010, 32'h00000020, 1'b1};
    tbl[10] = '{5'd1, 5'd2, 32'h00000010, 32'h00000020, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0,
                32'h00000010, 32'h00000020, 1'b0};
    tbl[11] = '{5'd12, 5'd13, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 5'd13, 32'h00001313,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0,
                32'h0, 32'h00001313, 1'b0};

    // reset held two cycles with a valid instruction in ID
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    drive_id(1'b1, 32'h40, 5'd1, 5'd2, 1'b1, 1'b1, 32'h5, 32'h6, 5'd3, 1'b1, 1'b1);
    drive_fw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("reset ex_opa", bus.ex_opa, 32'h0);
    chk("reset ex_opb", bus.ex_opb, 32'h0);
    chk("reset stall", {31'b0, bus.stall}, 32'h0);
    rst = 1'b0;

    // table: load one instruction, then check forwarding and stall in the following cycle
    for (int i = 0; i < 12; i++) begin
      drive_id(1'b1, 32'h1000 + 32'(i * 16), tbl[i].rs, tbl[i].rt, 1'b0, 1'b0,
               tbl[i].rd1, tbl[i].rd2, tbl[i].dst, 1'b1, tbl[i].mr);
      drive_fw(1'b0, 5'd0, 32'h0, tbl[i].lwrw, tbl[i].lwdst, tbl[i].lwwd);
      @(posedge clk);
      @(negedge clk);
      drive_id(1'b1, 32'h1004 + 32'(i * 16), tbl[i].nrs, tbl[i].nrt, tbl[i].nurs, tbl[i].nurt,
               32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      drive_fw(tbl[i].mrw, tbl[i].mdst, tbl[i].mres, tbl[i].wrw, tbl[i].wdst, tbl[i].wwd);
      #1;
      chk($sformatf("row%0d ex_pc", i), bus.ex_pc, 32'h1000 + 32'(i * 16));
      chk($sformatf("row%0d ex_opa", i), bus.ex_opa, tbl[i].opa);
      chk($sformatf("row%0d ex_opb", i), bus.ex_opb, tbl[i].opb);
      chk($sformatf("row%0d stall", i), {31'b0, bus.stall}, {31'b0, tbl[i].st});
    end

    // load-use: lw $3 followed by a dependent add costs exactly one bubble
    drive_id(1'b1, 32'h100, 5'd1, 5'd2, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1);
    drive_fw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_id(1'b1, 32'h104, 5'd3, 5'd4, 1'b1, 1'b1, 32'h00000BAD, 32'h4, 5'd5, 1'b1, 1'b0);
    #1;
    chk("lu ex_memread", {31'b0, bus.ex_memread}, 32'h1);
    chk("lu stall", {31'b0, bus.stall}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    drive_fw(1'b1, 5'd3, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("lu bubble ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("lu bubble ex_regwrite", {31'b0, bus.ex_regwrite}, 32'h0);
    chk("lu stall cleared", {31'b0, bus.stall}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_fw(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h00000055);
    #1;
    chk("lu add ex_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("lu add ex_pc", bus.ex_pc, 32'h104);
    chk("lu add ex_opa", bus.ex_opa, 32'h55);

    // hold with WB refresh; flush ignored while held
    drive_id(1'b1, 32'h200, 5'd11, 5'd9, 1'b0, 1'b0, 32'h7, 32'h1, 5'd12, 1'b1, 1'b0);
    drive_fw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_id(1'b1, 32'h300, 5'd1, 5'd2, 1'b0, 1'b0, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
    bus.hold  = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("hold ex_pc loaded", bus.ex_pc, 32'h200);
    chk("hold ex_opb loaded", bus.ex_opb, 32'h1);
    @(posedge clk);
    @(negedge clk);
    drive_fw(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hCAFEF00D);
    #1;
    chk("hold+flush ex_valid", {31'b0, bus.ex_valid}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    drive_fw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    bus.flush = 1'b0;
    #1;
    chk("hold refresh ex_opb", bus.ex_opb, 32'hCAFEF00D);
    chk("hold ex_pc", bus.ex_pc, 32'h200);
    chk("hold ex_ctrl", {16'b0, bus.ex_ctrl}, {16'b0, 16'h0200 ^ 16'hA5A5});
    chk("hold ex_imm", bus.ex_imm, ~32'h200);
    @(posedge clk);
    @(negedge clk);
    bus.hold  = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk("hold3 ex_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("hold3 ex_opb", bus.ex_opb, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("flush ex_regwrite", {31'b0, bus.ex_regwrite}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("resume ex_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("resume ex_pc", bus.ex_pc, 32'h300);
    rst      = 1'b1;
    bus.hold = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst+hold ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("rst+hold ex_pc", bus.ex_pc, 32'h0);
    chk("rst+hold ex_dst", {27'b0, bus.ex_dst}, 32'h0);
    chk("rst+hold ex_ctrl", {16'b0, bus.ex_ctrl}, 32'h0);
    chk("rst+hold ex_opa", bus.ex_opa, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
